wu_mem_arb: RTL and testbench

WU_MEM_ARB -- requirements
Module: wu_mem_arb

---
 rtl/wu_mem_arb_if.sv | 48 ++++
 rtl/wu_mem_arb.sv | 117 +++++++++++
 tb/tb_wu_mem_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wu_mem_arb_if.sv
// Bus bundle for the WU memory arbiter: fetch/loader request side and WU memory side.
// The arbiter connects through the slave modport; the environment uses the master modport.
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE 7:0
`endif
`ifndef MGR_WU_DATA_RANGE
`define MGR_WU_DATA_RANGE 31:0
`endif

interface wu_mem_arb_if;
    // fetch port
    logic                         wuf__wua__read_req;
    logic [`MGR_WU_ADDRESS_RANGE] wuf__wua__addr;
    logic                         wua__wuf__gnt;
    logic [`MGR_WU_DATA_RANGE]    wua__wuf__rdata;
    logic                         wua__wuf__rdata_valid;
    // loader port
    logic                         sys__wua__write_req;
    logic [`MGR_WU_ADDRESS_RANGE] sys__wua__addr;
    logic [`MGR_WU_DATA_RANGE]    sys__wua__wdata;
    logic                         wua__sys__gnt;
    // global stall
    logic                         xxx__wua__stall;
    // WU memory port
    logic                         wua__wum__read;
    logic                         wua__wum__write;
    logic [`MGR_WU_ADDRESS_RANGE] wua__wum__addr;
    logic [`MGR_WU_DATA_RANGE]    wua__wum__wdata;
    logic [`MGR_WU_DATA_RANGE]    wum__wua__rdata;

    modport slave (
        input  wuf__wua__read_req, wuf__wua__addr,
        input  sys__wua__write_req, sys__wua__addr, sys__wua__wdata,
        input  xxx__wua__stall, wum__wua__rdata,
        output wua__wuf__gnt, wua__wuf__rdata, wua__wuf__rdata_valid,
        output wua__sys__gnt,
        output wua__wum__read, wua__wum__write, wua__wum__addr, wua__wum__wdata
    );

    modport master (
        output wuf__wua__read_req, wuf__wua__addr,
        output sys__wua__write_req, sys__wua__addr, sys__wua__wdata,
        output xxx__wua__stall, wum__wua__rdata,
        input  wua__wuf__gnt, wua__wuf__rdata, wua__wuf__rdata_valid,
        input  wua__sys__gnt,
        input  wua__wum__read, wua__wum__write, wua__wum__addr, wua__wum__wdata
    );
endinterface

// File: rtl/wu_mem_arb.sv
// Single-port WU memory arbiter between instruction fetch (reads) and the loader (writes).
// Define WU_MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise the loader has fixed priority.
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE 7:0
`endif
`ifndef MGR_WU_DATA_RANGE
`define MGR_WU_DATA_RANGE 31:0
`endif

module wu_mem_arb (
    input  logic        clk,
    input  logic        reset_poweron,
    wu_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Read tracking stages from the memory strobe up to the capture of the memory data.
    localparam int RD_PIPE = 2;

    state_t                       state_q;
    logic                         gnt_fetch_d;
    logic                         gnt_load_d;
    logic                         read_q;
    logic                         write_q;
    logic [`MGR_WU_ADDRESS_RANGE] addr_q;
    logic [`MGR_WU_DATA_RANGE]    wdata_q;
    logic [`MGR_WU_DATA_RANGE]    rdata_q;
    logic                         rdata_valid_q;
    logic                         rd_pipe_q [RD_PIPE];

    always_comb begin
        gnt_fetch_d = 1'b0;
        gnt_load_d  = 1'b0;
        if (!reset_poweron && !bus.xxx__wua__stall) begin
            if (bus.wuf__wua__read_req && bus.sys__wua__write_req) begin
`ifdef WU_MEM_ARB_ROUND_ROBIN_EN
                if (state_q == ST_FETCH) begin
                    gnt_load_d = 1'b1;
                end else begin
                    gnt_fetch_d = 1'b1;
                end
`else
                gnt_load_d = 1'b1;
`endif
            end else begin
                gnt_fetch_d = bus.wuf__wua__read_req;
                gnt_load_d  = bus.sys__wua__write_req;
            end
        end
    end

    // Owner FSM and the registered memory command / read return.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q       <= ST_IDLE;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            read_q  <= gnt_fetch_d;
            write_q <= gnt_load_d;
            if (gnt_fetch_d) begin
                addr_q <= bus.wuf__wua__addr;
            end else if (gnt_load_d) begin
                addr_q  <= bus.sys__wua__addr;
                wdata_q <= bus.sys__wua__wdata;
            end

            rdata_valid_q <= rd_pipe_q[RD_PIPE-1];
            if (rd_pipe_q[RD_PIPE-1]) begin
                rdata_q <= bus.wum__wua__rdata;
            end

            if (bus.xxx__wua__stall) begin
                state_q <= state_q;
            end else if (gnt_fetch_d) begin
                state_q <= ST_FETCH;
            end else if (gnt_load_d) begin
                state_q <= ST_LOAD;
            end else if (!bus.wuf__wua__read_req && !bus.sys__wua__write_req) begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Stage 0 is the read strobe itself; later stages follow the memory latency.
    assign rd_pipe_q[0] = read_q;

    generate
        for (genvar gi = 1; gi < RD_PIPE; gi++) begin : g_rd_pipe
            always_ff @(posedge clk) begin
                if (reset_poweron) begin
                    rd_pipe_q[gi] <= 1'b0;
                end else begin
                    rd_pipe_q[gi] <= rd_pipe_q[gi-1];
                end
            end
        end
    endgenerate

    assign bus.wua__wuf__gnt         = gnt_fetch_d;
    assign bus.wua__sys__gnt         = gnt_load_d;
    assign bus.wua__wum__read        = read_q;
    assign bus.wua__wum__write       = write_q;
    assign bus.wua__wum__addr        = addr_q;
    assign bus.wua__wum__wdata       = wdata_q;
    assign bus.wua__wuf__rdata       = rdata_q;
    assign bus.wua__wuf__rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_wu_mem_arb.sv
// Scoreboard bench for wu_mem_arb: directed scenarios followed by random traffic,
// checked against a transaction-level model with a shadow copy of the WU memory.
`ifndef MGR_WU_ADDRESS_RANGE
`define MGR_WU_ADDRESS_RANGE 7:0
`endif
`ifndef MGR_WU_DATA_RANGE
`define MGR_WU_DATA_RANGE 31:0
`endif

module tb_wu_mem_arb;
    typedef logic [`MGR_WU_ADDRESS_RANGE] addr_t;
    typedef logic [`MGR_WU_DATA_RANGE]    data_t;
    localparam int DEPTH = 1 << $bits(addr_t);

    typedef struct {
        int    due;
        bit    rd;
        bit    wr;
        addr_t addr;
        data_t wdata;
    } cmd_t;

    typedef struct {
        int    due;
        data_t data;
    } ret_t;

    typedef enum {OWN_IDLE, OWN_FETCH, OWN_LOAD} own_t;

    logic clk = 1'b0;
    logic reset_poweron;
    always #5 clk = ~clk;

    wu_mem_arb_if bus ();

    wu_mem_arb dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .bus           (bus)
    );

    // WU memory: read data appears the cycle after the read strobe.
    data_t mem [DEPTH];
    data_t mem_rdata_q;
    assign bus.wum__wua__rdata = mem_rdata_q;
    always @(posedge clk) begin
        if (bus.wua__wum__read)  mem_rdata_q <= mem[bus.wua__wum__addr];
        if (bus.wua__wum__write) mem[bus.wua__wum__addr] <= bus.wua__wum__wdata;
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    data_t shadow [DEPTH];
    cmd_t  cmd_q [$];
    ret_t  ret_q [$];
    own_t  owner    = OWN_IDLE;
    bit    prev_rst = 1'b0;
    bit    gnt_f_s  = 1'b0;
    bit    gnt_l_s  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d actual=no_grant expected=grant", name, cyc);
    endtask

    // Monitor + scoreboard: check what the DUT presents this cycle, then push new expectations.
    always @(negedge clk) begin
        bit   exp_cmd;
        bit   exp_ret;
        bit   exp_f;
        bit   exp_l;
        bit   rq;
        bit   wq;
        cmd_t c;
        ret_t r;
        cyc++;

        if (prev_rst) begin
            chk("rst_strobes", 64'({bus.wua__wum__read, bus.wua__wum__write, bus.wua__wuf__rdata_valid}), 64'd0);
            chk("rst_addr",  64'(bus.wua__wum__addr),  64'd0);
            chk("rst_wdata", 64'(bus.wua__wum__wdata), 64'd0);
            chk("rst_rdata", 64'(bus.wua__wuf__rdata), 64'd0);
        end

        exp_cmd = (cmd_q.size() > 0) && (cmd_q[0].due == cyc);
        if (exp_cmd) begin
            c = cmd_q.pop_front();
            chk("cmd_strobes", 64'({bus.wua__wum__read, bus.wua__wum__write}), 64'({c.rd, c.wr}));
            chk("cmd_addr", 64'(bus.wua__wum__addr), 64'(c.addr));
            if (c.wr) chk("cmd_wdata", 64'(bus.wua__wum__wdata), 64'(c.wdata));
            $display("cyc %0d mem %s addr=%0h wdata=%0h", cyc, c.rd ? "read " : "write", c.addr, c.wdata);
        end else begin
            chk("cmd_strobes", 64'({bus.wua__wum__read, bus.wua__wum__write}), 64'd0);
        end

        exp_ret = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        chk("rdata_valid", 64'(bus.wua__wuf__rdata_valid), 64'(exp_ret));
        if (exp_ret) begin
            r = ret_q.pop_front();
            chk("rdata", 64'(bus.wua__wuf__rdata), 64'(r.data));
            $display("cyc %0d return rdata=%0h", cyc, r.data);
        end

        rq    = bus.wuf__wua__read_req;
        wq    = bus.sys__wua__write_req;
        exp_f = 1'b0;
        exp_l = 1'b0;
        if (!reset_poweron && !bus.xxx__wua__stall) begin
            if (rq && wq) begin
`ifdef WU_MEM_ARB_ROUND_ROBIN_EN
                if (owner == OWN_FETCH) exp_l = 1'b1;
                else                    exp_f = 1'b1;
`else
                exp_l = 1'b1;
`endif
            end else begin
                exp_f = rq;
                exp_l = wq;
            end
        end
        chk("grant", 64'({bus.wua__wuf__gnt, bus.wua__sys__gnt}), 64'({exp_f, exp_l}));

        if (reset_poweron) begin
            cmd_q.delete();
            ret_q.delete();
            owner = OWN_IDLE;
        end else begin
            if (exp_f) begin
                cmd_q.push_back('{due: cyc + 1, rd: 1'b1, wr: 1'b0, addr: bus.wuf__wua__addr, wdata: '0});
                ret_q.push_back('{due: cyc + 3, data: shadow[bus.wuf__wua__addr]});
            end
            if (exp_l) begin
                cmd_q.push_back('{due: cyc + 1, rd: 1'b0, wr: 1'b1, addr: bus.sys__wua__addr,
                                  wdata: bus.sys__wua__wdata});
                shadow[bus.sys__wua__addr] = bus.sys__wua__wdata;
            end
            if (!bus.xxx__wua__stall) begin
                if (exp_f)          owner = OWN_FETCH;
                else if (exp_l)     owner = OWN_LOAD;
                else if (!rq && !wq) owner = OWN_IDLE;
            end
        end

        prev_rst = reset_poweron;
        gnt_f_s  = bus.wua__wuf__gnt;
        gnt_l_s  = bus.wua__sys__gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt_f();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_f_s) return;
        end
        fail("fetch_grant_timeout");
    endtask

    task automatic wait_gnt_l();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_l_s) return;
        end
        fail("load_grant_timeout");
    endtask

    initial begin
        data_t v;
        for (int i = 0; i < DEPTH; i++) begin
            v         = data_t'($urandom);
            mem[i]    = v;
            shadow[i] = v;
        end
        mem[8'h10]    = data_t'(32'hA5);
        shadow[8'h10] = data_t'(32'hA5);

        reset_poweron           = 1'b1;
        bus.wuf__wua__read_req  = 1'b0;
        bus.wuf__wua__addr      = '0;
        bus.sys__wua__write_req = 1'b0;
        bus.sys__wua__addr      = '0;
        bus.sys__wua__wdata     = '0;
        bus.xxx__wua__stall     = 1'b0;
        repeat (3) tick();
        reset_poweron = 1'b0;
        tick();

        // single fetch of 0x10
        bus.wuf__wua__read_req = 1'b1;
        bus.wuf__wua__addr     = addr_t'(8'h10);
        wait_gnt_f();
        bus.wuf__wua__read_req = 1'b0;
        repeat (5) tick();

        // single loader write 0x3 <- 0x55
        bus.sys__wua__write_req = 1'b1;
        bus.sys__wua__addr      = addr_t'(8'h3);
        bus.sys__wua__wdata     = data_t'(32'h55);
        wait_gnt_l();
        bus.sys__wua__write_req = 1'b0;
        repeat (4) tick();

        // both requesters held for 4 cycles
        bus.wuf__wua__read_req  = 1'b1;
        bus.wuf__wua__addr      = addr_t'(8'h3);
        bus.sys__wua__write_req = 1'b1;
        bus.sys__wua__addr      = addr_t'(8'h4);
        bus.sys__wua__wdata     = data_t'(32'h1234);
        repeat (4) tick();
        bus.wuf__wua__read_req  = 1'b0;
        bus.sys__wua__write_req = 1'b0;
        repeat (4) tick();

        // stall for 3 cycles with both held, then one free cycle
        bus.wuf__wua__read_req  = 1'b1;
        bus.sys__wua__write_req = 1'b1;
        bus.xxx__wua__stall     = 1'b1;
        repeat (3) tick();
        bus.xxx__wua__stall = 1'b0;
        tick();
        bus.wuf__wua__read_req  = 1'b0;
        bus.sys__wua__write_req = 1'b0;
        repeat (4) tick();

        // reset one cycle after a fetch grant
        bus.wuf__wua__read_req = 1'b1;
        bus.wuf__wua__addr     = addr_t'(8'h21);
        wait_gnt_f();
        bus.wuf__wua__read_req = 1'b0;
        reset_poweron          = 1'b1;
        repeat (2) tick();
        reset_poweron = 1'b0;
        repeat (5) tick();

        // eight back-to-back fetches, addresses 0..7
        for (int i = 0; i < 8; i++) begin
            bus.wuf__wua__read_req = 1'b1;
            bus.wuf__wua__addr     = addr_t'(i);
            wait_gnt_f();
        end
        bus.wuf__wua__read_req = 1'b0;
        repeat (6) tick();

        // random traffic: requests hold until granted
        for (int n = 0; n < 600; n++) begin
            if (!bus.wuf__wua__read_req || gnt_f_s) begin
                bus.wuf__wua__read_req = ($urandom_range(0, 2) != 0);
                bus.wuf__wua__addr     = addr_t'($urandom_range(0, 15));
            end
            if (!bus.sys__wua__write_req || gnt_l_s) begin
                bus.sys__wua__write_req = ($urandom_range(0, 2) == 0);
                bus.sys__wua__addr      = addr_t'($urandom_range(0, 15));
                bus.sys__wua__wdata     = data_t'($urandom);
            end
            bus.xxx__wua__stall = ($urandom_range(0, 7) == 0);
            reset_poweron       = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset_poweron           = 1'b0;
        bus.xxx__wua__stall     = 1'b0;
        bus.wuf__wua__read_req  = 1'b0;
        bus.sys__wua__write_req = 1'b0;
        repeat (8) tick();

        chk("drain_cmd", 64'(cmd_q.size()), 64'd0);
        chk("drain_ret", 64'(ret_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
